// File: rtl/window4_collector.sv
// window4_collector: assembles a serial 8-bit sample stream into 4-sample windows.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready sample input;
//   flush drops a partial window; a..d (a oldest) with out_valid/out_ready and
//   out_seq present each window. SLIDE=0 tumbling, SLIDE=1 sliding windows.
module window4_collector #(
  parameter int SLIDE = 0,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       a,
  output logic [7:0]       b,
  output logic [7:0]       c,
  output logic [7:0]       d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEQ_W-1:0] out_seq
);

  logic [1:0]       fill;
  logic [7:0]       w0;
  logic [7:0]       w1;
  logic [7:0]       w2;
  logic [SEQ_W-1:0] cnt;
  logic             accept;
  logic             consume;
  logic             emit;

  // A new window may only land when the output slot is free or
  // being drained this same cycle.
  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign emit     = accept && (fill == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= 2'd0;
      w0        <= 8'd0;
      w1        <= 8'd0;
      w2        <= 8'd0;
      cnt       <= '0;
      a         <= 8'd0;
      b         <= 8'd0;
      c         <= 8'd0;
      d         <= 8'd0;
      out_valid <= 1'b0;
      out_seq   <= '0;
    end else begin
      if (flush) begin
        fill <= 2'd0;
      end else if (accept) begin
        if (SLIDE != 0) begin
          w0 <= w1;
          w1 <= w2;
          w2 <= in_data;
          // Once primed, every sample completes a window.
          if (fill != 2'd3) begin
            fill <= fill + 2'd1;
          end
        end else begin
          case (fill)
            2'd0:    w0 <= in_data;
            2'd1:    w1 <= in_data;
            2'd2:    w2 <= in_data;
            default: ;
          endcase
          // 3 wraps to 0 as the window is emitted.
          fill <= fill + 2'd1;
        end
      end

      // Emit uses pre-shift history, so a..c are the three older samples.
      if (emit) begin
        a         <= w0;
        b         <= w1;
        c         <= w2;
        d         <= in_data;
        out_valid <= 1'b1;
        out_seq   <= cnt;
        cnt       <= cnt + SEQ_W'(1);
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window4_collector.sv
// tb_window4_collector: directed checks of window4_collector in tumbling
// (u0) and sliding (u1) modes, including backpressure, flush, reset, seq wrap.
module tb_window4_collector;

  logic       clk;
  logic       rst;
  logic [7:0] id0, id1;
  logic       iv0, iv1;
  logic       ir0, ir1;
  logic       fl0, fl1;
  logic [7:0] a0, b0, c0, d0;
  logic [7:0] a1, b1, c1, d1;
  logic       ov0, ov1;
  logic       or0, or1;
  logic [7:0] sq0, sq1;

  int tests = 0;
  int fails = 0;

  window4_collector #(.SLIDE(0), .SEQ_W(8)) u0 (
    .clk(clk), .rst(rst), .in_data(id0), .in_valid(iv0),
    .in_ready(ir0), .flush(fl0), .a(a0), .b(b0), .c(c0),
    .d(d0), .out_valid(ov0), .out_ready(or0), .out_seq(sq0)
  );

  window4_collector #(.SLIDE(1), .SEQ_W(8)) u1 (
    .clk(clk), .rst(rst), .in_data(id1), .in_valid(iv1),
    .in_ready(ir1), .flush(fl1), .a(a1), .b(b1), .c(c1),
    .d(d1), .out_valid(ov1), .out_ready(or1), .out_seq(sq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] win(
    input logic v, input logic [7:0] wa, input logic [7:0] wb,
    input logic [7:0] wc, input logic [7:0] wd, input logic [7:0] s);
    return {v, wa, wb, wc, wd, s};
  endfunction

  function automatic logic [40:0] o0();
    return {ov0, a0, b0, c0, d0, sq0};
  endfunction

  function automatic logic [40:0] o1();
    return {ov1, a1, b1, c1, d1, sq1};
  endfunction

  task automatic chk(input string tag, input logic [40:0] obs,
                     input logic [40:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id0 = 8'd0; iv0 = 1'b0; fl0 = 1'b0; or0 = 1'b1;
    id1 = 8'd0; iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b1;
    step();
    #1 chk("rst_inready0", 41'(ir0), 41'(0));
    step();
    rst = 1'b0;
    #1;
    chk("reset_u0", o0(), '0);
    chk("reset_u1", o1(), '0);
    chk("inready_idle", 41'(ir0), 41'(1));

    // Tumbling, out_ready high: 1..8.
    iv0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      id0 = 8'(i);
      step();
      if (i == 3) chk("tum_lat", 41'(ov0), 41'(0));
      if (i == 4) chk("tum_w0", o0(), win(1, 1, 2, 3, 4, 0));
      if (i == 5) chk("tum_pulse", 41'(ov0), 41'(0));
      if (i == 8) chk("tum_w1", o0(), win(1, 5, 6, 7, 8, 1));
    end
    iv0 = 1'b0;
    step();
    chk("tum_pulse2", 41'(ov0), 41'(0));

    // Backpressure: window held, input stalled.
    rst = 1'b1;
    step();
    rst = 1'b0;
    or0 = 1'b0;
    iv0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id0 = 8'(i);
      step();
    end
    chk("bp_w0", o0(), win(1, 1, 2, 3, 4, 0));
    id0 = 8'd9;
    #1 chk("bp_stall", 41'(ir0), 41'(0));
    step();
    chk("bp_hold1", o0(), win(1, 1, 2, 3, 4, 0));
    step();
    chk("bp_hold2", o0(), win(1, 1, 2, 3, 4, 0));
    or0 = 1'b1;
    #1 chk("bp_release", 41'(ir0), 41'(1));
    step();
    chk("bp_consumed", 41'(ov0), 41'(0));
    for (int i = 10; i <= 12; i++) begin
      id0 = 8'(i);
      step();
    end
    chk("bp_w1", o0(), win(1, 9, 10, 11, 12, 1));

    // Flush of a partial tumbling window.
    iv0 = 1'b0;
    step();
    iv0 = 1'b1;
    id0 = 8'd7;
    step();
    id0 = 8'd8;
    step();
    fl0 = 1'b1;
    id0 = 8'd1;
    #1 chk("fl_inready", 41'(ir0), 41'(0));
    step();
    fl0 = 1'b0;
    step();
    id0 = 8'd2;
    step();
    chk("fl_noemit", 41'(ov0), 41'(0));
    id0 = 8'd3;
    step();
    id0 = 8'd4;
    step();
    chk("fl_win", o0(), win(1, 1, 2, 3, 4, 2));
    iv0 = 1'b0;
    or0 = 1'b0;
    fl0 = 1'b1;
    step();
    fl0 = 1'b0;
    chk("fl_pending", o0(), win(1, 1, 2, 3, 4, 2));
    or0 = 1'b1;
    step();

    // Reset mid-window, then reset with a window pending.
    iv0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id0 = 8'(i);
      step();
    end
    iv0 = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_mid", o0(), '0);
    rst = 1'b0;
    iv0 = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      id0 = 8'(i);
      step();
    end
    chk("rst_win", o0(), win(1, 5, 6, 7, 8, 0));
    iv0 = 1'b0;
    or0 = 1'b0;
    step();
    chk("rst_pend", o0(), win(1, 5, 6, 7, 8, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_drop", o0(), '0);
    or0 = 1'b1;

    // Sliding: 10..60.
    iv1 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      id1 = 8'(i * 10);
      step();
      if (i == 3) chk("sl_lat", 41'(ov1), 41'(0));
      if (i == 4) chk("sl_w0", o1(), win(1, 10, 20, 30, 40, 0));
      if (i == 5) chk("sl_w1", o1(), win(1, 20, 30, 40, 50, 1));
      if (i == 6) chk("sl_w2", o1(), win(1, 30, 40, 50, 60, 2));
    end
    iv1 = 1'b0;
    step();
    chk("sl_idle", 41'(ov1), 41'(0));

    // Sliding flush: history must be rebuilt from new samples.
    fl1 = 1'b1;
    step();
    fl1 = 1'b0;
    iv1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id1 = 8'(i);
      step();
      if (i == 1) chk("slfl_noemit", 41'(ov1), 41'(0));
    end
    chk("slfl_win", o1(), win(1, 1, 2, 3, 4, 3));

    // Sliding stream with seq wrap.
    iv1 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    iv1 = 1'b1;
    for (int i = 0; i < 260; i++) begin
      id1 = 8'(i);
      step();
      if (i < 3)
        chk("wrap_prime", 41'(ov1), 41'(0));
      else
        chk($sformatf("wrap_w%0d", i - 3), o1(),
            win(1, 8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i), 8'(i - 3)));
    end
    iv1 = 1'b0;
    step();
    chk("wrap_end", 41'(ov1), 41'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
